// File: rtl/data_mem_unit.sv
// -----------------------------------------------------------------------------
// data_mem_unit
//
// Data memory for the MEM stage of the pipeline. Reads are combinational and
// return the whole aligned word. Byte and halfword stores are merged into the
// word in big-endian lane order (byte offset 0 = bits [31:24]). Misaligned,
// out-of-range and illegal-size stores are rejected. The first such store is
// recorded in a sticky fault register. Committed stores are counted.
// A word-wide init port preloads the array and takes priority over a
// pipeline store in the same cycle.
//
// Parameters
//   ADDR_W           word-index width; the array holds 2**ADDR_W 32-bit words
//
// Ports
//   i_clk            clock; all state updates on the rising edge
//   i_rst_n          asynchronous active-low reset (fault/count only)
//   i_mem_addr       byte address
//   i_mem_write_data store data; sub-word data is right-justified
//   i_mem_wr         store request
//   i_mem_sb         store byte
//   i_mem_sh         store halfword
//   i_init_en        preload write enable
//   i_init_addr      preload word index
//   i_init_data      preload word
//   o_mem_read_data  aligned word at i_mem_addr, or 0 when out of range
//   o_fault          sticky fault flag
//   o_fault_addr     address of the first faulting store
//   o_store_count    committed pipeline stores, wraps modulo 2**32
// -----------------------------------------------------------------------------
module data_mem_unit #(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [31:0]       i_mem_addr,
  input  logic [31:0]       i_mem_write_data,
  input  logic              i_mem_wr,
  input  logic              i_mem_sb,
  input  logic              i_mem_sh,
  input  logic              i_init_en,
  input  logic [ADDR_W-1:0] i_init_addr,
  input  logic [31:0]       i_init_data,
  output logic [31:0]       o_mem_read_data,
  output logic              o_fault,
  output logic [31:0]       o_fault_addr,
  output logic [31:0]       o_store_count
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  logic [31:0]       r_mem [Depth];
  logic              r_fault;
  logic [31:0]       r_fault_addr;
  logic [31:0]       r_store_count;

  logic [ADDR_W-1:0] w_idx;
  logic [1:0]        w_off;
  logic              w_in_range;
  logic [31:0]       w_cur;
  logic              w_legal;
  logic [3:0]        w_be;
  logic [31:0]       w_lane_data;
  logic [31:0]       w_merged;
  logic              w_commit;
  logic              w_store_fault;
  logic              w_we;
  logic [ADDR_W-1:0] w_wr_idx;
  logic [31:0]       w_wr_data;

  assign w_idx      = i_mem_addr[ADDR_W+1:2];
  assign w_off      = i_mem_addr[1:0];
  assign w_in_range = (i_mem_addr[31:ADDR_W+2] == '0);
  assign w_cur      = r_mem[w_idx];

  assign o_mem_read_data = w_in_range ? w_cur : 32'h0;

  // Size/alignment decode. w_be bit 3 selects bits [31:24] (byte offset 0).
  always_comb begin
    w_legal     = 1'b0;
    w_be        = 4'b0000;
    w_lane_data = i_mem_write_data;
    unique case ({i_mem_sb, i_mem_sh})
      2'b10: begin
        w_legal     = 1'b1;
        w_be        = 4'b1000 >> w_off;
        w_lane_data = {4{i_mem_write_data[7:0]}};
      end
      2'b01: begin
        w_legal     = ~w_off[0];
        w_be        = w_off[1] ? 4'b0011 : 4'b1100;
        w_lane_data = {2{i_mem_write_data[15:0]}};
      end
      2'b00: begin
        w_legal     = (w_off == 2'b00);
        w_be        = 4'b1111;
        w_lane_data = i_mem_write_data;
      end
      default: begin
        w_legal     = 1'b0;
        w_be        = 4'b0000;
        w_lane_data = i_mem_write_data;
      end
    endcase
  end

  // Read-modify-write against the current array word, so back-to-back
  // sub-word stores to one word accumulate.
  always_comb begin
    w_merged = w_cur;
    for (int k = 0; k < 4; k++) begin
      if (w_be[3-k]) begin
        w_merged[31-8*k -: 8] = w_lane_data[31-8*k -: 8];
      end
    end
  end

  // A pipeline store coinciding with an init write is dropped entirely,
  // including its fault check.
  assign w_commit      = i_mem_wr & ~i_init_en & w_legal & w_in_range;
  assign w_store_fault = i_mem_wr & ~i_init_en & ~(w_legal & w_in_range);

  // Pipeline stores are suppressed while reset is asserted; init writes are
  // not, so a bench can preload during reset.
  assign w_we      = i_init_en | (w_commit & i_rst_n);
  assign w_wr_idx  = i_init_en ? i_init_addr : w_idx;
  assign w_wr_data = i_init_en ? i_init_data : w_merged;

  // Array has no reset: contents survive reset.
  always_ff @(posedge i_clk) begin
    if (w_we) begin
      r_mem[w_wr_idx] <= w_wr_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_fault       <= 1'b0;
      r_fault_addr  <= 32'h0;
      r_store_count <= 32'h0;
    end else begin
      if (w_store_fault && !r_fault) begin
        r_fault      <= 1'b1;
        r_fault_addr <= i_mem_addr;
      end
      if (w_commit) begin
        r_store_count <= r_store_count + 32'd1;
      end
    end
  end

  assign o_fault       = r_fault;
  assign o_fault_addr  = r_fault_addr;
  assign o_store_count = r_store_count;

endmodule

// File: tb/tb_data_mem_unit.sv
module tb_data_mem_unit;

  localparam int unsigned ADDR_W = 10;

  logic              clk;
  logic              rst_n;
  logic [31:0]       mem_addr;
  logic [31:0]       mem_write_data;
  logic              mem_wr;
  logic              mem_sb;
  logic              mem_sh;
  logic              init_en;
  logic [ADDR_W-1:0] init_addr;
  logic [31:0]       init_data;
  logic [31:0]       mem_read_data;
  logic              fault;
  logic [31:0]       fault_addr;
  logic [31:0]       store_count;

  int checks;
  int failures;

  data_mem_unit #(
    .ADDR_W(ADDR_W)
  ) u_dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_mem_addr      (mem_addr),
    .i_mem_write_data(mem_write_data),
    .i_mem_wr        (mem_wr),
    .i_mem_sb        (mem_sb),
    .i_mem_sh        (mem_sh),
    .i_init_en       (init_en),
    .i_init_addr     (init_addr),
    .i_init_data     (init_data),
    .o_mem_read_data (mem_read_data),
    .o_fault         (fault),
    .o_fault_addr    (fault_addr),
    .o_store_count   (store_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Preload one word through the init port.
  task automatic preload(input logic [ADDR_W-1:0] idx, input logic [31:0] data);
    @(negedge clk);
    init_en   = 1'b1;
    init_addr = idx;
    init_data = data;
    @(posedge clk);
    #1;
    init_en = 1'b0;
  endtask

  // One-cycle pipeline store; returns 1 time unit after the edge with wr low.
  task automatic store(input logic [31:0] addr, input logic [31:0] data,
                       input logic sb, input logic sh);
    @(negedge clk);
    mem_addr       = addr;
    mem_write_data = data;
    mem_wr         = 1'b1;
    mem_sb         = sb;
    mem_sh         = sh;
    @(posedge clk);
    #1;
    mem_wr = 1'b0;
    mem_sb = 1'b0;
    mem_sh = 1'b0;
  endtask

  // Combinational read at addr.
  task automatic read_check(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    mem_addr = addr;
    #1;
    check(tag, mem_read_data, exp);
  endtask

  initial begin
    checks         = 0;
    failures       = 0;
    rst_n          = 1'b0;
    mem_addr       = 32'h0;
    mem_write_data = 32'h0;
    mem_wr         = 1'b0;
    mem_sb         = 1'b0;
    mem_sh         = 1'b0;
    init_en        = 1'b0;
    init_addr      = '0;
    init_data      = 32'h0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_fault", {31'h0, fault}, 32'h0);
    check("rst_fault_addr", fault_addr, 32'h0);
    check("rst_count", store_count, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Preload and word store
    preload(10'd0, 32'h55555555);
    preload(10'd4, 32'h11223344);
    read_check("preload_w4", 32'h10, 32'h11223344);
    store(32'h10, 32'hDEADBEEF, 1'b0, 1'b0);
    read_check("word_store", 32'h10, 32'hDEADBEEF);
    check("count_after_word", store_count, 32'd1);

    // Byte lanes, big-endian
    preload(10'd4, 32'h11223344);
    store(32'h10, 32'h000000AA, 1'b1, 1'b0);
    read_check("sb_off0", 32'h10, 32'hAA223344);
    store(32'h11, 32'h000000AA, 1'b1, 1'b0);
    read_check("sb_off1", 32'h10, 32'hAAAA3344);
    store(32'h12, 32'h000000AA, 1'b1, 1'b0);
    read_check("sb_off2", 32'h10, 32'hAAAAAA44);
    store(32'h13, 32'h000000AA, 1'b1, 1'b0);
    read_check("sb_off3", 32'h10, 32'hAAAAAAAA);
    check("count_after_bytes", store_count, 32'd5);

    // Halfwords
    preload(10'd4, 32'h11223344);
    store(32'h12, 32'h0000BEEF, 1'b0, 1'b1);
    read_check("sh_off2", 32'h10, 32'h1122BEEF);
    store(32'h10, 32'h0000BEEF, 1'b0, 1'b1);
    read_check("sh_off0", 32'h10, 32'hBEEFBEEF);
    check("count_after_half", store_count, 32'd7);

    // wr low with size strobes high is a no-op
    @(negedge clk);
    mem_addr       = 32'h10;
    mem_write_data = 32'h00000077;
    mem_sb         = 1'b1;
    @(posedge clk);
    #1;
    mem_sb = 1'b0;
    read_check("nowr_noop", 32'h10, 32'hBEEFBEEF);
    check("nowr_count", store_count, 32'd7);

    // Faults
    check("no_fault_yet", {31'h0, fault}, 32'h0);
    store(32'h11, 32'h00001234, 1'b0, 1'b1);
    read_check("mis_sh_nowrite", 32'h10, 32'hBEEFBEEF);
    check("fault_set", {31'h0, fault}, 32'h1);
    check("fault_addr_first", fault_addr, 32'h11);
    check("fault_count", store_count, 32'd7);
    store(32'h00001002, 32'h12345678, 1'b0, 1'b0);
    check("fault_addr_held", fault_addr, 32'h11);
    store(32'h10, 32'h12345678, 1'b1, 1'b1);
    read_check("illegal_nowrite", 32'h10, 32'hBEEFBEEF);
    store(32'h00010000, 32'hCAFEF00D, 1'b0, 1'b0);
    read_check("oor_read_zero", 32'h00010000, 32'h0);
    read_check("oor_no_alias", 32'h0, 32'h55555555);
    check("fault_count2", store_count, 32'd7);
    check("fault_addr_held2", fault_addr, 32'h11);

    // Init has priority over a same-cycle store
    @(negedge clk);
    init_en        = 1'b1;
    init_addr      = 10'd5;
    init_data      = 32'h01020304;
    mem_addr       = 32'h10;
    mem_write_data = 32'h0BADF00D;
    mem_wr         = 1'b1;
    @(posedge clk);
    #1;
    init_en = 1'b0;
    mem_wr  = 1'b0;
    read_check("prio_init_word", 32'h14, 32'h01020304);
    read_check("prio_store_drop", 32'h10, 32'hBEEFBEEF);
    check("prio_count", store_count, 32'd7);

    // Async reset between edges
    @(posedge clk);
    #3;
    mem_addr = 32'h10;
    rst_n    = 1'b0;
    #1;
    check("async_rst_fault", {31'h0, fault}, 32'h0);
    check("async_rst_count", store_count, 32'h0);
    check("async_rst_faddr", fault_addr, 32'h0);
    check("async_rst_keep", mem_read_data, 32'hBEEFBEEF);

    // Store during reset is suppressed
    store(32'h10, 32'h99999999, 1'b0, 1'b0);
    read_check("rst_store_supp", 32'h10, 32'hBEEFBEEF);
    check("rst_store_count", store_count, 32'h0);

    // First store after release is accepted
    @(negedge clk);
    rst_n = 1'b1;
    store(32'h10, 32'h13572468, 1'b0, 1'b0);
    read_check("post_rst_store", 32'h10, 32'h13572468);
    check("post_rst_count", store_count, 32'd1);

    // Back-to-back byte stores to one word merge
    @(negedge clk);
    mem_addr       = 32'h10;
    mem_write_data = 32'h00000001;
    mem_wr         = 1'b1;
    mem_sb         = 1'b1;
    @(negedge clk);
    mem_addr       = 32'h13;
    mem_write_data = 32'h00000002;
    @(posedge clk);
    #1;
    mem_wr = 1'b0;
    mem_sb = 1'b0;
    read_check("b2b_merge", 32'h10, 32'h01572402);
    check("b2b_count", store_count, 32'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
